// File: rtl/cbc_stream_encipher.sv
// cbc_stream_encipher
// Streaming CBC/ECB encryption engine built around a single combinational
// 16-bit PRESENT-style block cipher (present_encipher, 20-bit key, 6 rounds).
// One plaintext block is accepted per cycle. The ciphertext appears one cycle
// later in a single output register, which can hold under backpressure.
//
// Optional build macro: CBC_STREAM_MAC_EN
//   When it is defined, the mac_tag/mac_valid outputs are added. They carry the
//   final CBC ciphertext of each message as a CBC-MAC tag.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for cfg_load; any pending output can still drain
// RUN   | message open; plaintext blocks are accepted while in_ready is high

module present_encipher (
    input  logic [15:0] plaintext,
    input  logic [19:0] key,
    output logic [15:0] ciphertext
);

    localparam int ROUNDS = 6;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    logic [15:0] blk;
    logic [15:0] sub;
    logic [19:0] rkey;

    // Unrolled rounds: add round key, S-box layer, bit transpose, key update
    always_comb begin
        blk  = plaintext;
        rkey = key;
        sub  = '0;
        for (int r = 1; r <= ROUNDS; r++) begin
            blk = blk ^ rkey[19:4];
            for (int n = 0; n < 4; n++) begin
                sub[4*n +: 4] = sbox(blk[4*n +: 4]);
            end
            // Bit i moves to the transposed position of a 4x4 bit matrix.
            for (int i = 0; i < 16; i++) begin
                blk[4*(i%4) + (i/4)] = sub[i];
            end
            rkey         = {rkey[6:0], rkey[19:7]};
            rkey[19:16]  = sbox(rkey[19:16]);
            rkey[8:4]    = rkey[8:4] ^ 5'(r);
        end
        ciphertext = blk ^ rkey[19:4];
    end

endmodule

module cbc_stream_encipher #(
    parameter int BLOCK_W    = 16,
    parameter int KEY_W      = 20,
    parameter int MAX_BLOCKS = 8,
    parameter int CNT_W      = $clog2(MAX_BLOCKS) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [KEY_W-1:0]   cfg_key,
    input  logic [BLOCK_W-1:0] cfg_iv,
    input  logic               cfg_ecb,
    output logic               busy,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               out_last,
    output logic               err_len
`ifdef CBC_STREAM_MAC_EN
    ,
    output logic [BLOCK_W-1:0] mac_tag,
    output logic               mac_valid
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BLOCKS - 1);

    logic [0:0]         state_r;
    logic [KEY_W-1:0]   key_r;
    logic               ecb_r;
    // The chain register is loaded with the IV at cfg_load, so it also acts
    // as the IV register until the first block of the message is accepted.
    logic [BLOCK_W-1:0] chain_r;
    logic [CNT_W-1:0]   cnt_r;

    logic               out_valid_r;
    logic [BLOCK_W-1:0] out_data_r;
    logic               out_last_r;
    logic               err_len_r;

    logic               accept;
    logic               msg_end;
    logic               forced_end;
    logic [BLOCK_W-1:0] core_in;
    logic [BLOCK_W-1:0] core_out;

    // Handshake and chaining datapath for the current input block
    always_comb begin
        in_ready   = (state_r == ST_RUN) && (!out_valid_r || out_ready);
        accept     = in_valid && in_ready;
        forced_end = (cnt_r == CNT_LAST) && !in_last;
        msg_end    = in_last || (cnt_r == CNT_LAST);
        core_in    = ecb_r ? in_data : (in_data ^ chain_r);
    end

    present_encipher u_core (
        .plaintext  (core_in),
        .key        (key_r),
        .ciphertext (core_out)
    );

    // Message control: configuration latch, chain value, block count, state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            key_r   <= '0;
            ecb_r   <= 1'b0;
            chain_r <= '0;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cfg_load) begin
                        key_r   <= cfg_key;
                        ecb_r   <= cfg_ecb;
                        chain_r <= cfg_iv;
                        cnt_r   <= '0;
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (msg_end) begin
                            chain_r <= '0;
                            cnt_r   <= '0;
                            state_r <= ST_IDLE;
                        end else begin
                            chain_r <= core_out;
                            cnt_r   <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Single-entry output register: loads on accept, retires on out_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            err_len_r   <= 1'b0;
        end else begin
            err_len_r <= 1'b0;
            if (accept) begin
                out_valid_r <= 1'b1;
                out_data_r  <= core_out;
                out_last_r  <= msg_end;
                err_len_r   <= forced_end;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end
        end
    end

    assign busy      = (state_r == ST_RUN);
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign err_len   = err_len_r;

`ifdef CBC_STREAM_MAC_EN
    logic [BLOCK_W-1:0] mac_tag_r;
    logic               mac_valid_r;

    // Capture the last CBC ciphertext of each message as its tag
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_tag_r   <= '0;
            mac_valid_r <= 1'b0;
        end else begin
            mac_valid_r <= 1'b0;
            if (accept && msg_end && !ecb_r) begin
                mac_tag_r   <= core_out;
                mac_valid_r <= 1'b1;
            end
        end
    end

    assign mac_tag   = mac_tag_r;
    assign mac_valid = mac_valid_r;
`endif

endmodule

// File: tb/tb_cbc_stream_encipher.sv
// Scoreboard bench for cbc_stream_encipher: instance A uses MAX_BLOCKS=8 and
// instance B uses MAX_BLOCKS=4. They share one stimulus bus, and sel picks
// which instance sees in_valid/cfg_load.
module tb_cbc_stream_encipher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cfg_load, cfg_ecb;
    logic [19:0] cfg_key;
    logic [15:0] cfg_iv;
    logic        in_valid, in_last, out_ready;
    logic [15:0] in_data;
    logic        sel;

    logic        cfg_load_a, cfg_load_b, in_valid_a, in_valid_b;
    logic        busy_a, in_ready_a, out_valid_a, out_last_a, err_len_a;
    logic        busy_b, in_ready_b, out_valid_b, out_last_b, err_len_b;
    logic [15:0] out_data_a, out_data_b;
    logic        in_ready_m;
`ifdef CBC_STREAM_MAC_EN
    logic [15:0] mac_tag_a, mac_tag_b;
    logic        mac_valid_a, mac_valid_b;
`endif

    assign cfg_load_a = cfg_load & ~sel;
    assign cfg_load_b = cfg_load & sel;
    assign in_valid_a = in_valid & ~sel;
    assign in_valid_b = in_valid & sel;
    assign in_ready_m = sel ? in_ready_b : in_ready_a;

    cbc_stream_encipher #(.MAX_BLOCKS(8)) u_dut_a (
        .clk(clk), .rst(rst), .cfg_load(cfg_load_a), .cfg_key(cfg_key),
        .cfg_iv(cfg_iv), .cfg_ecb(cfg_ecb), .busy(busy_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_last(out_last_a), .err_len(err_len_a)
`ifdef CBC_STREAM_MAC_EN
        , .mac_tag(mac_tag_a), .mac_valid(mac_valid_a)
`endif
    );

    cbc_stream_encipher #(.MAX_BLOCKS(4)) u_dut_b (
        .clk(clk), .rst(rst), .cfg_load(cfg_load_b), .cfg_key(cfg_key),
        .cfg_iv(cfg_iv), .cfg_ecb(cfg_ecb), .busy(busy_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_last(out_last_b), .err_len(err_len_b)
`ifdef CBC_STREAM_MAC_EN
        , .mac_tag(mac_tag_b), .mac_valid(mac_valid_b)
`endif
    );

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        err;
        logic        mac;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [15:0] cap_a[$];
    int          cyc_a[$];
    logic [15:0] s1_cap[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int err_a = 0, err_b = 0, mac_a = 0, exp_mac_a = 0;
    int last_acc_cyc = 0;

    // reference model state
    logic [19:0] m_key;
    logic [15:0] m_chain;
    logic        m_ecb;
    logic        m_run = 1'b0;
    int          m_cnt = 0;
    int          m_max = 8;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Golden cipher: nibble S-box from a packed table and bit permutation 4i mod 15
    function automatic logic [15:0] enc(input logic [19:0] key, input logic [15:0] pt);
        logic [63:0] sb;
        logic [15:0] s, t;
        logic [19:0] k;
        sb = 64'h2174_8FE3_DA09_B65C;
        s = pt;
        k = key;
        t = '0;
        for (int r = 1; r <= 6; r++) begin
            s = s ^ k[19:4];
            for (int n = 0; n < 4; n++) t[n*4 +: 4] = sb[int'(s[n*4 +: 4])*4 +: 4];
            for (int i = 0; i < 16; i++) s[(i == 15) ? 15 : (i*4) % 15] = t[i];
            k = {k[6:0], k[19:7]};
            k[19:16] = sb[int'(k[19:16])*4 +: 4];
            k[8:4] = k[8:4] ^ 5'(r);
        end
        return s ^ k[19:4];
    endfunction

    // Monitor A: pop and compare on every output handshake
    always @(negedge clk) begin
        exp_t e;
        if (out_valid_a && out_ready) begin
            cap_a.push_back(out_data_a);
            cyc_a.push_back(cyc);
            if (q_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_output actual=%h required=none", out_data_a);
            end else begin
                e = q_a.pop_front();
                chk("a_data", {16'h0, out_data_a}, {16'h0, e.data});
                chk("a_last", {31'h0, out_last_a}, {31'h0, e.last});
                chk("a_err_len", {31'h0, err_len_a}, {31'h0, e.err});
`ifdef CBC_STREAM_MAC_EN
                chk("a_mac_valid", {31'h0, mac_valid_a}, {31'h0, e.mac});
`endif
            end
        end
        if (err_len_a) err_a++;
`ifdef CBC_STREAM_MAC_EN
        if (mac_valid_a) mac_a++;
`endif
    end

    // Monitor B
    always @(negedge clk) begin
        exp_t e;
        if (out_valid_b && out_ready) begin
            if (q_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_output actual=%h required=none", out_data_b);
            end else begin
                e = q_b.pop_front();
                chk("b_data", {16'h0, out_data_b}, {16'h0, e.data});
                chk("b_last", {31'h0, out_last_b}, {31'h0, e.last});
                chk("b_err_len", {31'h0, err_len_b}, {31'h0, e.err});
            end
        end
        if (err_len_b) err_b++;
    end

    task automatic do_cfg(input logic [19:0] k, input logic [15:0] iv, input logic ecb);
        cfg_key = k;
        cfg_iv = iv;
        cfg_ecb = ecb;
        cfg_load = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        m_key = k;
        m_chain = iv;
        m_ecb = ecb;
        m_cnt = 0;
        m_run = 1'b1;
        m_max = sel ? 4 : 8;
    endtask

    task automatic send_block(input logic [15:0] d, input logic last);
        exp_t e;
        logic [15:0] c;
        logic endm, seen;
        int waited;
        in_data = d;
        in_last = last;
        in_valid = 1'b1;
        if (!m_run) begin
            seen = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (in_ready_m) seen = 1'b1;
            end
            chk("no_accept_when_idle", {31'h0, seen}, 32'h0);
        end else begin
            c = enc(m_key, m_ecb ? d : (d ^ m_chain));
            endm = last || (m_cnt == m_max - 1);
            e.data = c;
            e.last = endm;
            e.err = endm && !last;
            e.mac = endm && !m_ecb;
            if (sel) q_b.push_back(e);
            else begin
                q_a.push_back(e);
                if (e.mac) exp_mac_a++;
            end
            m_chain = endm ? 16'h0 : c;
            m_cnt++;
            if (endm) m_run = 1'b0;
            waited = 0;
            forever begin
                @(negedge clk);
                if (in_ready_m) break;
                waited++;
                if (waited >= 50) begin
                    checks++;
                    failures++;
                    $display("FAIL accept_timeout actual=no_in_ready required=accept block=%h", d);
                    break;
                end
            end
            last_acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_acc;
        logic [15:0] held;
        rst = 1'b1;
        cfg_load = 1'b0;
        cfg_ecb = 1'b0;
        cfg_key = '0;
        cfg_iv = '0;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'h0, busy_a}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready_a}, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid_a}, 32'h0);
        chk("rst_out_data", {16'h0, out_data_a}, 32'h0);
        chk("rst_out_last", {31'h0, out_last_a}, 32'h0);
        chk("rst_err_len", {31'h0, err_len_a}, 32'h0);
        chk("rst_b_in_ready", {31'h0, in_ready_b}, 32'h0);
`ifdef CBC_STREAM_MAC_EN
        chk("rst_mac_tag", {16'h0, mac_tag_a}, 32'h0);
        chk("rst_mac_valid", {31'h0, mac_valid_a}, 32'h0);
`endif
        @(posedge clk);
        #1;

        // Scenario 1: basic CBC, 8 back-to-back blocks
        do_cfg(20'hABCDE, 16'h1234, 1'b0);
        cyc_a.delete();
        cap_a.delete();
        first_acc = 0;
        for (int i = 0; i < 8; i++) begin
            send_block(16'(i), i == 7);
            if (i == 0) first_acc = last_acc_cyc;
        end
        @(negedge clk);
        chk("s1_busy_after_last", {31'h0, busy_a}, 32'h0);
        repeat (2) @(negedge clk);
        chk("s1_out_count", cyc_a.size(), 8);
        for (int i = 0; i < cyc_a.size() && i < 8; i++)
            chk("s1_out_cycle", cyc_a[i], first_acc + 1 + i);
        s1_cap = cap_a;
`ifdef CBC_STREAM_MAC_EN
        repeat (3) @(negedge clk);
        if (s1_cap.size() == 8) chk("s1_mac_tag_hold", {16'h0, mac_tag_a}, {16'h0, s1_cap[7]});
`endif
        @(posedge clk);
        #1;

        // Scenario 2a: ECB, two identical blocks give identical ciphertext
        do_cfg(20'h00001, 16'h0000, 1'b1);
        cap_a.delete();
        send_block(16'h5555, 1'b0);
        send_block(16'h5555, 1'b1);
        repeat (3) @(negedge clk);
        chk("ecb_out_count", cap_a.size(), 2);
        if (cap_a.size() == 2) chk("ecb_equal", {16'h0, cap_a[1]}, {16'h0, cap_a[0]});
        @(posedge clk);
        #1;

        // Scenario 2b: CBC on the same blocks; cfg_load during RUN is ignored
        do_cfg(20'h00001, 16'h0000, 1'b0);
        cfg_key = 20'hFFFFF;
        cfg_iv = 16'hFFFF;
        cfg_ecb = 1'b1;
        cfg_load = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        cap_a.delete();
        send_block(16'h5555, 1'b0);
        send_block(16'h5555, 1'b1);
        repeat (3) @(negedge clk);
        chk("cbc_out_count", cap_a.size(), 2);
        if (cap_a.size() == 2) chk("cbc_differs", {31'h0, cap_a[1] != cap_a[0]}, 32'h1);
        @(posedge clk);
        #1;

        // Scenario 3: backpressure for 3 cycles mid-message
        do_cfg(20'h13579, 16'hC0DE, 1'b0);
        fork
            begin
                for (int i = 0; i < 8; i++) send_block(16'h1000 + 16'(i) * 16'h0111, i == 7);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                held = out_data_a;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk("bp_out_valid", {31'h0, out_valid_a}, 32'h1);
                    chk("bp_in_ready", {31'h0, in_ready_a}, 32'h0);
                    chk("bp_hold", {16'h0, out_data_a}, {16'h0, held});
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;

        // Scenario 4: reset after 3 of 8 blocks, then a clean rerun of scenario 1
        do_cfg(20'hABCDE, 16'h1234, 1'b0);
        for (int i = 0; i < 3; i++) send_block(16'(i), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_run = 1'b0;
        @(negedge clk);
        chk("rstmid_out_valid", {31'h0, out_valid_a}, 32'h0);
        chk("rstmid_busy", {31'h0, busy_a}, 32'h0);
        chk("rstmid_in_ready", {31'h0, in_ready_a}, 32'h0);
        @(posedge clk);
        #1;
        do_cfg(20'hABCDE, 16'h1234, 1'b0);
        cap_a.delete();
        for (int i = 0; i < 8; i++) send_block(16'(i), i == 7);
        repeat (3) @(negedge clk);
        chk("rerun_out_count", cap_a.size(), 8);
        for (int i = 0; i < cap_a.size() && i < s1_cap.size(); i++)
            chk("rerun_matches_s1", {16'h0, cap_a[i]}, {16'h0, s1_cap[i]});
        @(posedge clk);
        #1;

        // Scenario 5: truncation on the MAX_BLOCKS=4 instance, then restart with a new IV
        sel = 1'b1;
        do_cfg(20'h0F0F0, 16'hBEEF, 1'b0);
        for (int i = 0; i < 6; i++) send_block(16'hA000 + 16'(i), 1'b0);
        do_cfg(20'h0F0F0, 16'h0042, 1'b0);
        send_block(16'hB001, 1'b0);
        send_block(16'hB002, 1'b1);
        repeat (4) @(negedge clk);
        sel = 1'b0;

        chk("queue_a_drained", q_a.size(), 0);
        chk("queue_b_drained", q_b.size(), 0);
        chk("err_pulses_a", err_a, 0);
        chk("err_pulses_b", err_b, 1);
`ifdef CBC_STREAM_MAC_EN
        chk("mac_pulses_a", mac_a, exp_mac_a);
        if (cap_a.size() == 8) chk("mac_tag_final", {16'h0, mac_tag_a}, {16'h0, cap_a[7]});
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cbc_stream_encipher.md
Name: cbc_stream_encipher

Overview:
- Sequential, parametrised CBC encryption engine built around one combinational present_encipher core.
- Processes messages of up to MAX_BLOCKS 16-bit blocks, accepting one block per cycle through a valid/ready stream.
- Key and IV are latched per message; the chain value is held in a register.
- A runtime mode selects CBC or ECB; length violations are flagged.
- Sits between the plaintext packet source and the ciphertext sink, and is the streaming form of the fixed 8-block unrolled CBC chain.

Parameters:
- BLOCK_W, 16, block width; must equal the present_encipher data width.
- KEY_W, 20, key width; must equal the present_encipher key width.
- MAX_BLOCKS, 8, maximum blocks per message; legal range 1..256.
- CNT_W, $clog2(MAX_BLOCKS)+1, block counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- cfg_load  input  1  latch key/iv/mode; honoured only in IDLE.
- cfg_key  input  KEY_W  key.
- cfg_iv  input  BLOCK_W  initialisation vector.
- cfg_ecb  input  1  0 = CBC, 1 = ECB (IV ignored).
- busy  output  1  high in RUN.
- in_valid  input  1  plaintext block valid.
- in_ready  output  1  engine can accept a block.
- in_data  input  BLOCK_W  plaintext block.
- in_last  input  1  final block of the message.
- out_valid  output  1  ciphertext valid.
- out_ready  input  1  sink accepts ciphertext.
- out_data  output  BLOCK_W  ciphertext block.
- out_last  output  1  final ciphertext block of the message.
- err_len  output  1  one-cycle pulse when a message is truncated at MAX_BLOCKS.

Behaviour:
- Reset values:
  - busy=0, in_ready=0, out_valid=0, out_data=0, out_last=0, err_len=0.
  - Key, IV, chain and counter registers are 0; state is IDLE.
- States:
  - IDLE: in_ready=0. cfg_load=1 latches key_r, iv_r, ecb_r, sets chain_r=iv_r source value, clears cnt, and moves to RUN next cycle.
  - RUN: in_ready = !out_valid || out_ready (single output register, full throughput).
- Block acceptance (accept = in_valid && in_ready):
  - Core input = ecb_r ? in_data : (in_data ^ chain_r).
  - out_data <= core output; out_valid <= 1; chain_r <= core output; cnt <= cnt+1.
- Latency: exactly 1 cycle from accept to out_valid.
- Output hold: while out_valid && !out_ready, out_data, out_last and out_valid hold stable and in_ready=0.
- Message end:
  - Occurs on accept with in_last=1, or on accept with cnt == MAX_BLOCKS-1 (forced end).
  - On message end: out_last <= 1, state returns to IDLE, chain_r cleared.
  - The pending output still drains normally from IDLE.
- Forced end (MAX_BLOCKS reached without in_last): err_len pulses for 1 cycle, coincident with out_valid rising. Any later blocks of that message are not accepted, since in_ready=0 in IDLE.
- MAX_BLOCKS=1: every accepted block is a message; out_last=1 always. err_len pulses only if in_last=0.
- cfg_load in RUN: ignored; latched values are unchanged.
- Simultaneous out_ready and a new accept: old output retires and new output loads in the same cycle, with no bubble.
- Reset mid-message: all state returns to reset values next edge. The partially emitted message is discarded and the sink must tolerate a missing out_last.
- out_last is cleared when a non-final block is loaded, and when out_valid drops.

Optional Feature:
- Macro: CBC_STREAM_MAC_EN.
- When defined:
  - Adds outputs mac_tag [BLOCK_W] and mac_valid [1].
  - On message end, mac_tag <= final ciphertext and mac_valid pulses 1 cycle, coincident with out_valid for the last block.
  - mac_tag holds until the next message end. Reset value is 0.
  - In ECB mode mac_valid never asserts.
- When undefined: ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Basic CBC, iv=16'h1234, key=20'hABCDE, 8 blocks 16'h0000..16'h0007 in back-to-back cycles, out_ready=1 -> 8 outputs on consecutive cycles, each equal to golden E(k, p_i ^ c_{i-1}) with c_{-1}=16'h1234; out_last only on block 7; busy drops after the 8th accept.
- ECB vs CBC, two identical blocks 16'h5555, key=20'h00001, iv=0:
  - ECB -> out_data equal for both blocks.
  - CBC -> second output = E(k, c0 ^ 16'h5555), different from the first.
- Backpressure: out_ready low for 3 cycles mid-message -> in_ready=0 and out_data stable throughout; no block lost or duplicated; sequence matches golden.
- Truncation, MAX_BLOCKS=4, send 6 blocks with in_last never set -> 4 outputs, out_last on the 4th, err_len pulses once, blocks 5-6 not accepted; a new cfg_load restarts cleanly with chain = new iv.
- Reset after 3 of 8 blocks accepted -> next cycle out_valid=0, busy=0, in_ready=0; a fresh message with iv=16'h1234 reproduces the scenario 1 outputs.
- With CBC_STREAM_MAC_EN, scenario 1 -> mac_valid pulses with the 8th output; mac_tag = the 8th ciphertext and holds afterward.
